// File: rtl/rsa_stream_io.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : rsa_stream_io                                                 |
// | Description : Streaming load/unload front end for the rsa4k core. Collects  |
// |               message, exponent and modulus as DATA_WIDTH words, pulses go, |
// |               waits for a fresh rising edge of done, captures cypher and    |
// |               streams the result back out least-significant word first.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module rsa_stream_io #(
  parameter int RSA_WIDTH  = 4096,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [RSA_WIDTH-1:0]  message,
  output logic [RSA_WIDTH-1:0]  exponent,
  output logic [RSA_WIDTH-1:0]  modulus,
  output logic                  go,
  input  logic [RSA_WIDTH-1:0]  cypher,
  input  logic                  done
);

  localparam int WORDS  = RSA_WIDTH / DATA_WIDTH;
  localparam int SLOT_W = $clog2(WORDS);
  localparam int LANE_W = $clog2(DATA_WIDTH);
  localparam int CNT_W  = 8;
  localparam int OP_W   = CNT_W - SLOT_W;

  localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(3 * WORDS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORDS - 1);
  localparam logic [OP_W-1:0]   OP_MSG    = OP_W'(0);
  localparam logic [OP_W-1:0]   OP_EXP    = OP_W'(1);
  localparam logic [OP_W-1:0]   OP_MOD    = OP_W'(2);

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UNLOAD  = 3'd4
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        word_cnt_q;
  logic                    done_q;
  logic [RSA_WIDTH-1:0]    message_q;
  logic [RSA_WIDTH-1:0]    exponent_q;
  logic [RSA_WIDTH-1:0]    modulus_q;
  logic [RSA_WIDTH-1:0]    result_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    m_valid_q;
  logic                    m_last_q;
  logic                    s_ready_q;
  logic                    busy_q;
  logic                    go_q;

  // The low counter bits pick the word slot, the high bits pick the operand.
  logic [SLOT_W-1:0]        w_slot;
  logic [SLOT_W-1:0]        w_slot_nxt;
  logic [OP_W-1:0]          w_opsel;
  logic [SLOT_W+LANE_W-1:0] w_off;
  logic [SLOT_W+LANE_W-1:0] w_off_nxt;

  assign w_slot     = word_cnt_q[SLOT_W-1:0];
  assign w_opsel    = word_cnt_q[CNT_W-1:SLOT_W];
  assign w_slot_nxt = w_slot + SLOT_W'(1);
  assign w_off      = {w_slot, {LANE_W{1'b0}}};
  assign w_off_nxt  = {w_slot_nxt, {LANE_W{1'b0}}};

  // Control FSM with all handshake, status and operand outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
      message_q  <= '0;
      exponent_q <= '0;
      modulus_q  <= '0;
      result_q   <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      s_ready_q  <= 1'b1;
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      done_q <= done;
      go_q   <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (s_valid && s_ready_q) begin
            if (w_opsel == OP_MSG) begin
              message_q[w_off +: DATA_WIDTH] <= s_data;
            end else if (w_opsel == OP_EXP) begin
              exponent_q[w_off +: DATA_WIDTH] <= s_data;
            end else if (w_opsel == OP_MOD) begin
              modulus_q[w_off +: DATA_WIDTH] <= s_data;
            end
            if (word_cnt_q == LOAD_LAST) begin
              word_cnt_q <= '0;
              s_ready_q  <= 1'b0;
              go_q       <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ST_START;
            end else begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Only a fresh edge counts; a level left over from the last run does not.
          if (done && !done_q) begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          result_q   <= cypher;
          m_data_q   <= cypher[DATA_WIDTH-1:0];
          m_last_q   <= (SLOT_LAST == '0);
          m_valid_q  <= 1'b1;
          busy_q     <= 1'b0;
          word_cnt_q <= '0;
          state_q    <= ST_UNLOAD;
        end
        ST_UNLOAD: begin
          if (m_ready) begin
            if (w_slot == SLOT_LAST) begin
              m_valid_q  <= 1'b0;
              m_last_q   <= 1'b0;
              s_ready_q  <= 1'b1;
              word_cnt_q <= '0;
              state_q    <= ST_LOAD;
            end else begin
              m_data_q   <= result_q[w_off_nxt +: DATA_WIDTH];
              m_last_q   <= (w_slot_nxt == SLOT_LAST);
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign busy     = busy_q;
  assign go       = go_q;
  assign message  = message_q;
  assign exponent = exponent_q;
  assign modulus  = modulus_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_stream_io.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_rsa_stream_io                                              |
// | Description : Directed bench for rsa_stream_io with a small rsa4k model.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_rsa_stream_io;

  localparam int RSA_WIDTH  = 4096;
  localparam int DATA_WIDTH = 64;
  localparam int WORDS      = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  busy;
  logic [RSA_WIDTH-1:0]  message;
  logic [RSA_WIDTH-1:0]  exponent;
  logic [RSA_WIDTH-1:0]  modulus;
  logic                  go;
  logic [RSA_WIDTH-1:0]  cypher;
  logic                  done;
  logic [63:0]           salt;

  int n_vec  = 0;
  int n_err  = 0;
  int go_cnt = 0;
  int core_t;

  always #5 clk = ~clk;

  rsa_stream_io #(
    .RSA_WIDTH (RSA_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .message (message),
    .exponent(exponent),
    .modulus (modulus),
    .go      (go),
    .cypher  (cypher),
    .done    (done)
  );

  function automatic logic [63:0] cy_word(input int k, input logic [63:0] s);
    return 64'hA5A5_0000_0000_0000 + 64'(k) + {s[31:0], 32'h0};
  endfunction

  // Core result: word k carries the reference pattern plus the job salt.
  for (genvar k = 0; k < WORDS; k++) begin : g_cypher
    assign cypher[k*DATA_WIDTH +: DATA_WIDTH] = cy_word(k, salt);
  end

  // Core model: done held high until go, then raised again 100 cycles later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b1;
      core_t <= 0;
    end else if (go) begin
      done   <= 1'b0;
      core_t <= 100;
    end else if (core_t != 0) begin
      core_t <= core_t - 1;
      if (core_t == 1) done <= 1'b1;
    end
  end

  always @(negedge clk) if (go === 1'b1) go_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    check({tag, "_go"},      64'(go),      64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_last"},  64'(m_last),  64'd0);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_m_data"},  m_data,       64'd0);
    check({tag, "_msg_zero"}, 64'(message  == '0), 64'd1);
    check({tag, "_exp_zero"}, 64'(exponent == '0), 64'd1);
    check({tag, "_mod_zero"}, 64'(modulus  == '0), 64'd1);
  endtask

  task automatic check_ops(input int base);
    for (int k = 0; k < WORDS; k++) begin
      check($sformatf("msg[%0d]", k), message[k*DATA_WIDTH +: DATA_WIDTH],  64'(base + k));
      check($sformatf("exp[%0d]", k), exponent[k*DATA_WIDTH +: DATA_WIDTH], 64'(base + WORDS + k));
      check($sformatf("mod[%0d]", k), modulus[k*DATA_WIDTH +: DATA_WIDTH],  64'(base + 2*WORDS + k));
    end
  endtask

  // Streams 192 words of value base+i; returns at the negedge after the last accept.
  task automatic load_job(input int base, input bit gaps);
    int  i     = 0;
    int  guard = 0;
    bit  v;
    while (i < 3*WORDS && guard < 5000) begin
      @(negedge clk);
      guard++;
      v       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_valid = v;
      s_data  = 64'(base + i);
      if (v && s_ready === 1'b1) i++;
    end
    check("load_complete", 64'(i), 64'(3*WORDS));
    @(negedge clk);
    s_valid = 1'b0;
    check("go_after_last", 64'(go), 64'd1);
    check("s_ready_low", 64'(s_ready), 64'd0);
  endtask

  // Returns at the negedge where the first result word is presented.
  task automatic wait_completion();
    int n   = 0;
    bit bad = 1'b0;
    while (done !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
      if (m_valid !== 1'b0) bad = 1'b1;
    end
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (m_valid !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) bad = 1'b1;
    end
    check("no_stale_capture", 64'(bad), 64'd0);
    check("done_in_time", 64'(n < 300), 64'd1);
    @(negedge clk);
    check("capture_busy", 64'(busy), 64'd1);
    check("capture_m_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("unload_m_valid", 64'(m_valid), 64'd1);
    check("unload_busy", 64'(busy), 64'd0);
  endtask

  // Consumes result words 0..stop_at-1; with bp set, m_ready follows 1-0-0-1.
  task automatic unload(input logic [63:0] s, input bit bp, input int stop_at);
    int k   = 0;
    int cyc = 0;
    bit rdy;
    while (k < stop_at && cyc < 1000) begin
      check($sformatf("m_valid[%0d]", k), 64'(m_valid), 64'd1);
      check($sformatf("m_data[%0d]", k),  m_data, cy_word(k, s));
      check($sformatf("m_last[%0d]", k),  64'(m_last), 64'(k == WORDS-1));
      rdy     = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      m_ready = rdy;
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    int g0;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    salt    = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_reset_vals("idle");
    end

    // Job A: full-rate load, full-rate unload.
    g0 = go_cnt;
    load_job(0, 1'b0);
    check_ops(0);
    wait_completion();
    check("go_once_a", 64'(go_cnt - g0), 64'd1);
    unload(64'd0, 1'b0, WORDS);
    check("a_end_s_ready", 64'(s_ready), 64'd1);
    check("a_end_m_valid", 64'(m_valid), 64'd0);

    // Job B: reset while waiting for the core.
    load_job(1000, 1'b0);
    repeat (20) @(negedge clk);
    check("b_wait_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_wait");
    @(negedge clk);
    reset = 1'b0;

    // Job C: gapped load, backpressured unload.
    salt = 64'd1;
    g0   = go_cnt;
    load_job(0, 1'b1);
    check_ops(0);
    wait_completion();
    check("go_once_c", 64'(go_cnt - g0), 64'd1);
    unload(64'd1, 1'b1, WORDS);
    check("c_end_s_ready", 64'(s_ready), 64'd1);
    check("c_end_m_valid", 64'(m_valid), 64'd0);

    // Job D: reset partway through the result stream.
    salt = 64'd2;
    load_job(2000, 1'b0);
    check_ops(2000);
    wait_completion();
    unload(64'd2, 1'b0, 20);
    check("d_word20", m_data, cy_word(20, 64'd2));
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_unload");
    @(negedge clk);
    reset = 1'b0;

    // Job E: fresh job after the reset.
    salt = 64'd3;
    g0   = go_cnt;
    load_job(3000, 1'b0);
    check_ops(3000);
    wait_completion();
    check("go_once_e", 64'(go_cnt - g0), 64'd1);
    unload(64'd3, 1'b0, WORDS);
    check("e_end_s_ready", 64'(s_ready), 64'd1);
    check("e_end_m_valid", 64'(m_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
